// File: rtl/serial_frame_receiver.sv
// Deserializes the readout stream: RTC field, then memory words from alternating banks.
// Flags malformed frames and reports each frame end with its word count.
module serial_frame_receiver #(
  parameter int RTC_WIDTH  = 31,
  parameter int WORD_WIDTH = 16,
  parameter int BANK_DEPTH = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_frame,
  input  logic                  rx_sel,
  input  logic                  rx_valid,
  input  logic                  rx_data,
  output logic [RTC_WIDTH-1:0]  rtc_out,
  output logic                  rtc_valid,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  word_bank,
  output logic                  word_valid,
  output logic                  frame_done,
  output logic [15:0]           word_count,
  output logic                  frame_error
);

  localparam int MAXW = (RTC_WIDTH > WORD_WIDTH) ? RTC_WIDTH : WORD_WIDTH;
  localparam int SW   = MAXW - 1;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] RTC_LAST  = CW'(RTC_WIDTH - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BANK_DEPTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RTC  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic                  frame_q;
  logic [CW-1:0]         bit_cnt;
  logic [SW-1:0]         sh;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  bank;
  logic [15:0]           cnt;

  logic cap;
  logic start;
  logic ending;

  assign cap   = rx_frame & rx_valid;
  assign start = rx_frame & ~frame_q;
  // any active state closes the frame when rx_frame drops
  assign ending = ~rx_frame &
                  ((state == S_RTC) | (state == S_DATA) | (state == S_ERR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      frame_q     <= 1'b0;
      bit_cnt     <= '0;
      sh          <= '0;
      addr        <= '0;
      bank        <= 1'b0;
      cnt         <= '0;
      rtc_out     <= '0;
      rtc_valid   <= 1'b0;
      word_out    <= '0;
      word_addr   <= '0;
      word_bank   <= 1'b0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      word_count  <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_q    <= rx_frame;
      rtc_valid  <= 1'b0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            frame_error <= 1'b0;
            addr        <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            state       <= S_RTC;
            if (cap) begin
              if (rx_sel) begin
                frame_error <= 1'b1;
                state       <= S_ERR;
              end else begin
                sh      <= {sh[SW-2:0], rx_data};
                bit_cnt <= CW'(1);
              end
            end
          end
        end

        S_RTC: begin
          if (!rx_frame) begin
            frame_error <= 1'b1;
          end else if (cap) begin
            if (rx_sel) begin
              frame_error <= 1'b1;
              state       <= S_ERR;
            end else if (bit_cnt == RTC_LAST) begin
              rtc_out   <= {sh[RTC_WIDTH-2:0], rx_data};
              rtc_valid <= 1'b1;
              bit_cnt   <= '0;
              state     <= S_DATA;
            end else begin
              sh      <= {sh[SW-2:0], rx_data};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (!rx_frame) begin
            if (bit_cnt != '0) frame_error <= 1'b1;
          end else if (cap) begin
            if (!rx_sel) begin
              frame_error <= 1'b1;
              state       <= S_ERR;
            end else if (bit_cnt == WORD_LAST) begin
              word_out   <= {sh[WORD_WIDTH-2:0], rx_data};
              word_addr  <= addr;
              word_bank  <= bank;
              word_valid <= 1'b1;
              bit_cnt    <= '0;
              if (addr == ADDR_LAST) begin
                addr <= '0;
                bank <= ~bank;
              end else begin
                addr <= addr + 1'b1;
              end
              if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end else begin
              sh      <= {sh[SW-2:0], rx_data};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_ERR: begin
          state <= S_ERR;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (ending) begin
        frame_done <= 1'b1;
        word_count <= cnt;
        state      <= S_DONE;
        // transmitter moves on to the other bank after a partial bank
        if ((cnt != 16'd0) && (addr != '0)) bank <= ~bank;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomized directed frames checked against a frame-level model of the receiver.
// Model derives words, addresses, banks and errors from the frame description.
module tb_serial_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_frame;
  logic        rx_sel;
  logic        rx_valid;
  logic        rx_data;
  logic [30:0] rtc_out;
  logic        rtc_valid;
  logic [15:0] word_out;
  logic [7:0]  word_addr;
  logic        word_bank;
  logic        word_valid;
  logic        frame_done;
  logic [15:0] word_count;
  logic        frame_error;

  serial_frame_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .rx_frame   (rx_frame),
    .rx_sel     (rx_sel),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rtc_out    (rtc_out),
    .rtc_valid  (rtc_valid),
    .word_out   (word_out),
    .word_addr  (word_addr),
    .word_bank  (word_bank),
    .word_valid (word_valid),
    .frame_done (frame_done),
    .word_count (word_count),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic mbank = 1'b0;
  logic [15:0] wbuf [300];

  logic [24:0] wq [$];
  logic [30:0] rq [$];
  logic [16:0] dq [$];
  int cyc = 0;
  int last_wv = 0;
  int last_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      wq.push_back({word_bank, word_addr, word_out});
      last_wv <= cyc;
    end
    if (rtc_valid) rq.push_back(rtc_out);
    if (frame_done) begin
      dq.push_back({word_count, frame_error});
      last_fd <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rtc"}, 64'(rtc_out), 64'd0);
    check({tag, "_outs"},
          64'({rtc_valid, word_out, word_addr, word_bank, word_valid,
               frame_done, word_count, frame_error}), 64'd0);
  endtask

  task automatic step(input logic f, input logic s, input logic v,
                      input logic d);
    rx_frame = f;
    rx_sel   = s;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic d, input int gap);
    if ($urandom_range(99) < gap)
      step(1'b1, 1'($urandom), 1'b0, 1'($urandom));
    step(1'b1, s, 1'b1, d);
  endtask

  task automatic send_frame(input logic [30:0] rtc, input int nw,
                            input int rtc_bits, input int bad_rtc,
                            input int part, input int bad_data,
                            input int gap, input bit abort);
    bit   ok_rtc;
    bit   err;
    int   nwe;
    logic b;
    wq.delete();
    rq.delete();
    dq.delete();
    for (int i = 0; i < rtc_bits; i++)
      send_bit(i == bad_rtc, rtc[30-i], gap);
    if (rtc_bits == 31) begin
      for (int w = 0; w < nw; w++) begin
        if (w == bad_data) send_bit(1'b0, 1'($urandom), gap);
        for (int k = 0; k < 16; k++)
          send_bit(1'b1, wbuf[w][15-k], gap);
      end
      if (bad_data == nw) send_bit(1'b0, 1'b1, gap);
      for (int k = 0; k < part; k++)
        send_bit(1'b1, 1'($urandom), gap);
    end
    if (abort) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      reset    = 1'b1;
      rx_frame = 1'b0;
      rx_valid = 1'b0;
      rx_sel   = 1'b0;
      @(negedge clk);
      check_zero("abort");
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    ok_rtc = (rtc_bits == 31) && (bad_rtc < 0);
    nwe = !ok_rtc ? 0 :
          ((bad_data >= 0) && (bad_data < nw)) ? bad_data : nw;
    err = !ok_rtc || (bad_data >= 0) || (part > 0);

    check("rtc_n", 64'(rq.size()), 64'(ok_rtc));
    if (ok_rtc && rq.size() > 0) check("rtc_val", 64'(rq[0]), 64'(rtc));
    check("word_n", 64'(wq.size()), 64'(nwe));
    for (int i = 0; i < nwe && i < wq.size(); i++) begin
      b = mbank ^ (((i / 200) % 2) == 1);
      check($sformatf("word%0d", i), 64'(wq[i]),
            64'({b, 8'(i % 200), wbuf[i]}));
    end
    if (abort) begin
      check("abort_done_n", 64'(dq.size()), 64'd0);
      mbank = 1'b0;
    end else begin
      check("done_n", 64'(dq.size()), 64'd1);
      if (dq.size() > 0) begin
        check("count", 64'(dq[0][16:1]), 64'(nwe));
        check("err", 64'(dq[0][0]), 64'(err));
      end
      check("sticky_err", 64'(frame_error), 64'(err));
      if (!err && nwe > 0)
        check("order", 64'(last_fd - last_wv), 64'd1);
      if (((nwe / 200) % 2) == 1) mbank = ~mbank;
      if ((nwe % 200) != 0) mbank = ~mbank;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_zero("reset");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    mbank = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_frame = 1'b0;
    rx_sel   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // nominal short frame, bit captured on the rising-edge cycle
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hBEEF;
    wbuf[2] = 16'h0001;
    send_frame(31'h2AAAAAAA, 3, 31, -1, 0, -1, 0, 1'b0);
    fill_random(3);
    send_frame(31'($urandom), 3, 31, -1, 0, -1, 25, 1'b0);

    do_reset();
    fill_random(250);
    send_frame(31'($urandom), 250, 31, -1, 0, -1, 20, 1'b0);

    send_frame(31'($urandom), 0, 20, -1, 0, -1, 20, 1'b0);
    send_frame(31'($urandom), 0, 31, -1, 7, -1, 20, 1'b0);
    send_frame(31'($urandom), 2, 31, 10, 0, -1, 20, 1'b0);
    fill_random(5);
    send_frame(31'($urandom), 5, 31, -1, 0, -1, 20, 1'b0);
    fill_random(4);
    send_frame(31'($urandom), 4, 31, -1, 0, 2, 20, 1'b0);
    fill_random(3);
    send_frame(31'($urandom), 3, 31, -1, 0, -1, 20, 1'b0);

    fill_random(2);
    send_frame(31'($urandom), 2, 31, -1, 0, -1, 20, 1'b1);
    fill_random(3);
    send_frame(31'($urandom), 3, 31, -1, 0, -1, 20, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(10);
      fill_random(n);
      send_frame(31'($urandom), n, 31, -1, 0, -1, 30, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
